// File: rtl/lightsout_move_tracker_if.sv
`default_nettype none
// ============================================================================
// lightsout_move_tracker_if : game-core strobe/board in, display/status out
// Revision: 1.0
// ============================================================================
interface lightsout_move_tracker_if;
  logic       press;
  logic [8:0] board;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic       win;
  logic       playing;
  logic [7:0] move_bcd;
  logic [7:0] best_bcd;

  modport master (
    output press, board,
    input  seg, dig_sel, win, playing, move_bcd, best_bcd
  );

  modport slave (
    input  press, board,
    output seg, dig_sel, win, playing, move_bcd, best_bcd
  );
endinterface
`default_nettype wire

// File: rtl/lightsout_move_tracker.sv
`default_nettype none
// ============================================================================
// lightsout_move_tracker : game phase FSM, BCD move counter and 2-digit
// multiplexed 7-segment display. Optional macro: LIGHTSOUT_BEST_SCORE_EN.
// Revision: 1.0
// ============================================================================
module lightsout_move_tracker #(
  parameter int SCAN_DIV   = 1024,
  parameter int FLASH_BITS = 20
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  lightsout_move_tracker_if.slave  bus
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] c_seg_dash  = 7'b1000000;
  localparam logic [6:0] c_seg_blank = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_SOLVED  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                press_q;
  logic [7:0]          move_q, move_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [1:0]          dig_sel_q, dig_sel_d;
  logic [FLASH_BITS-1:0] flash_q, flash_d;
  logic [6:0]          seg_q, seg_d;
  logic                win_q, playing_q;
  logic [7:0]          best_q, best_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      bcd_inc = v;
    else if (v[3:0] == 4'd9)
      bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else
      bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // Phase and counter decisions use the delayed press with the post-press board.
  always_comb begin
    state_d = state_q;
    move_d  = move_q;
    if (press_q) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.board != 9'd0) begin
            state_d = ST_PLAYING;
            move_d  = 8'h00;
          end
        end
        ST_PLAYING: begin
          move_d = bcd_inc(move_q);
          if (bus.board == 9'd0)
            state_d = ST_SOLVED;
        end
        ST_SOLVED: begin
          if (bus.board != 9'd0) begin
            state_d = ST_PLAYING;
            move_d  = 8'h00;
          end
        end
        default: begin
          state_d = ST_IDLE;
          move_d  = 8'h00;
        end
      endcase
    end
  end

`ifdef LIGHTSOUT_BEST_SCORE_EN
  always_comb begin
    best_d = best_q;
    if (state_q == ST_PLAYING && state_d == ST_SOLVED && move_d < best_q)
      best_d = move_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N)
      best_q <= 8'h99;
    else
      best_q <= best_d;
  end
`else
  assign best_d = 8'h00;
  assign best_q = 8'h00;
`endif

  always_comb begin
    scan_d    = scan_q + SCAN_W'(1);
    dig_sel_d = dig_sel_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d    = '0;
      dig_sel_d = ~dig_sel_q;
    end
    flash_d = flash_q + FLASH_BITS'(1);
  end

  // Segment data is built from next-cycle values so it lands with dig_sel.
  always_comb begin
    seg_d = c_seg_dash;
    case (state_d)
      ST_PLAYING: seg_d = seg7(dig_sel_d[1] ? move_d[7:4] : move_d[3:0]);
      ST_SOLVED: begin
        if (flash_d[FLASH_BITS-1])
          seg_d = seg7(dig_sel_d[1] ? move_d[7:4] : move_d[3:0]);
        else
`ifdef LIGHTSOUT_BEST_SCORE_EN
          seg_d = seg7(dig_sel_d[1] ? best_d[7:4] : best_d[3:0]);
`else
          seg_d = c_seg_blank;
`endif
      end
      default: seg_d = c_seg_dash;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      press_q   <= 1'b0;
      move_q    <= 8'h00;
      scan_q    <= '0;
      dig_sel_q <= 2'b01;
      flash_q   <= '0;
      seg_q     <= c_seg_dash;
      win_q     <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      press_q   <= bus.press;
      move_q    <= move_d;
      scan_q    <= scan_d;
      dig_sel_q <= dig_sel_d;
      flash_q   <= flash_d;
      seg_q     <= seg_d;
      win_q     <= (state_d == ST_SOLVED);
      playing_q <= (state_d == ST_PLAYING);
    end
  end

  assign bus.seg      = seg_q;
  assign bus.dig_sel  = dig_sel_q;
  assign bus.win      = win_q;
  assign bus.playing  = playing_q;
  assign bus.move_bcd = move_q;
  assign bus.best_bcd = best_q;

endmodule
`default_nettype wire

// File: tb/tb_lightsout_move_tracker.sv
`default_nettype none
// ============================================================================
// tb_lightsout_move_tracker : vector table, directed corner sequences and
// random stimulus against a behavioural game model.
// Revision: 1.0
// ============================================================================
module tb_lightsout_move_tracker;

  localparam int SD = 2;
  localparam int FB = 4;
`ifdef LIGHTSOUT_BEST_SCORE_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  lightsout_move_tracker_if bus();

  lightsout_move_tracker #(.SCAN_DIV(SD), .FLASH_BITS(FB)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Model: phase 0=idle 1=playing 2=solved, counts as plain integers.
  int m_phase, m_moves, m_best, m_n;
  bit m_pd;
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    logic       p;
    logic [8:0] b;
    logic       e_play;
    logic       e_win;
    logic [7:0] e_move;
  } vec_t;

  vec_t vecs [16];

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic p, input logic [8:0] b);
    if (!r) begin
      m_phase = 0; m_moves = 0; m_best = 99; m_pd = 0; m_n = 0;
    end else begin
      if (m_pd) begin
        if (m_phase == 0 && b != 0) begin
          m_phase = 1; m_moves = 0;
        end else if (m_phase == 1) begin
          m_moves = (m_moves < 99) ? m_moves + 1 : 99;
          if (b == 0) begin
            m_phase = 2;
            if (m_moves < m_best) m_best = m_moves;
          end
        end else if (m_phase == 2 && b != 0) begin
          m_phase = 1; m_moves = 0;
        end
      end
      m_pd = p;
      m_n++;
    end
  endtask

  task automatic check_model();
    int tens, dig, fl, v, exp_seg, exp_best;
    tens = (m_n / SD) % 2;
    dig  = tens ? 2'b10 : 2'b01;
    fl   = ((m_n % (1 << FB)) >> (FB - 1)) & 1;
    exp_best = BEST_EN ? to_bcd(m_best) : 0;
    if (m_phase == 0) exp_seg = 7'b1000000;
    else begin
      v = (m_phase == 2 && fl == 0) ? m_best : m_moves;
      if (m_phase == 2 && fl == 0 && !BEST_EN) exp_seg = 0;
      else exp_seg = segtab[tens ? v / 10 : v % 10];
    end
    chk("m_seg", bus.seg, exp_seg);
    chk("m_dig", bus.dig_sel, dig);
    chk("m_win", bus.win, m_phase == 2);
    chk("m_play", bus.playing, m_phase == 1);
    chk("m_move", bus.move_bcd, to_bcd(m_moves));
    chk("m_best", bus.best_bcd, exp_best);
  endtask

  // Called at a negedge: drive, take the edge, then compare at the next negedge.
  task automatic step(input logic p, input logic [8:0] b, input logic r = 1'b1);
    RESET_N = r; bus.press = p; bus.board = b;
    @(posedge CLK);
    model_edge(r, p, b);
    @(negedge CLK);
    check_model();
  endtask

  task automatic do_reset();
    step(1'b0, 9'd0, 1'b0);
  endtask

  // Starts a game (from idle or solved) and solves it in k moves.
  task automatic play_game(input int k);
    step(1'b1, 9'h1FF); step(1'b0, 9'h1FF);
    for (int i = 1; i < k; i++) begin
      step(1'b1, 9'h1FF); step(1'b0, 9'h1FF);
    end
    step(1'b1, 9'h1FF); step(1'b0, 9'h000);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_move"}, bus.move_bcd, 8'h00);
    chk({tag, "_dig"}, bus.dig_sel, 2'b01);
    chk({tag, "_seg"}, bus.seg, 7'b1000000);
    chk({tag, "_win"}, bus.win, 0);
    chk({tag, "_play"}, bus.playing, 0);
    chk({tag, "_best"}, bus.best_bcd, BEST_EN ? 8'h99 : 8'h00);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 9'h000, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 9'h000, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 9'h000, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 9'h0A5, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 9'h0A5, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 9'h0A5, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 9'h0A5, 1'b1, 1'b0, 8'h01};
    vecs[7]  = '{1'b0, 9'h0A5, 1'b1, 1'b0, 8'h02};
    vecs[8]  = '{1'b0, 9'h000, 1'b1, 1'b0, 8'h02};
    vecs[9]  = '{1'b1, 9'h001, 1'b1, 1'b0, 8'h02};
    vecs[10] = '{1'b0, 9'h000, 1'b0, 1'b1, 8'h03};
    vecs[11] = '{1'b1, 9'h000, 1'b0, 1'b1, 8'h03};
    vecs[12] = '{1'b0, 9'h000, 1'b0, 1'b1, 8'h03};
    vecs[13] = '{1'b1, 9'h0FF, 1'b0, 1'b1, 8'h03};
    vecs[14] = '{1'b0, 9'h0FF, 1'b1, 1'b0, 8'h00};
    vecs[15] = '{1'b0, 9'h0FF, 1'b1, 1'b0, 8'h00};

    bus.press = 1'b0; bus.board = 9'd0;
    @(negedge CLK);
    do_reset(); do_reset();
    check_reset_values("rst");

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].p, vecs[i].b);
      chk($sformatf("tbl%0d_play", i), bus.playing, vecs[i].e_play);
      chk($sformatf("tbl%0d_win", i), bus.win, vecs[i].e_win);
      chk($sformatf("tbl%0d_move", i), bus.move_bcd, vecs[i].e_move);
    end

    // Ten presses after entering play give BCD 10.
    do_reset();
    step(1'b1, 9'h0A5); step(1'b0, 9'h0A5);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 9'h0A5); step(1'b0, 9'h0A5);
    end
    chk("ten_move", bus.move_bcd, 8'h10);

    // Saturation at 99, then a solving press keeps 99.
    do_reset();
    step(1'b1, 9'h1FF); step(1'b0, 9'h1FF);
    for (int i = 0; i < 105; i++) begin
      step(1'b1, 9'h1FF); step(1'b0, 9'h1FF);
    end
    chk("sat_move", bus.move_bcd, 8'h99);
    step(1'b1, 9'h1FF); step(1'b0, 9'h000);
    chk("sat_win", bus.win, 1);
    chk("sat_move2", bus.move_bcd, 8'h99);

    // Solve in 5 and watch the flash alternate.
    do_reset();
    play_game(5);
    chk("five_move", bus.move_bcd, 8'h05);
    for (int i = 0; i < 20; i++) step(1'b0, 9'h000);

    // Best score tracking across games.
    do_reset();
    play_game(12);
    chk("best12", bus.best_bcd, BEST_EN ? 8'h12 : 8'h00);
    play_game(7);
    chk("best7", bus.best_bcd, BEST_EN ? 8'h07 : 8'h00);
    play_game(9);
    chk("best9", bus.best_bcd, BEST_EN ? 8'h07 : 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 9'h000);
      if (((m_n % (1 << FB)) >> (FB - 1)) == 0 && bus.dig_sel == 2'b01)
        chk("flash0_ones", bus.seg, BEST_EN ? 7'b0000111 : 7'b0000000);
    end

    // Reset mid-game at 23 moves.
    step(1'b1, 9'h1FF); step(1'b0, 9'h1FF);
    for (int i = 0; i < 23; i++) begin
      step(1'b1, 9'h1FF); step(1'b0, 9'h1FF);
    end
    chk("mid_move", bus.move_bcd, 8'h23);
    do_reset();
    check_reset_values("mid");

    // Random play against the model.
    for (int i = 0; i < 600; i++) begin
      logic p;
      logic [8:0] b;
      p = ($urandom_range(0, 1) == 1);
      b = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom);
      step(p, b, ($urandom_range(0, 299) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
